// File: rtl/gray_codec_pipe_if.sv
// Streaming handshake bundle for the Gray/binary converter pipe.
// The master drives items in and accepts results; the slave is the converter.
interface gray_codec_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [WIDTH-1:0] out_data;
    logic             out_adj_err;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_adj_err
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_adj_err
    );
endinterface

// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready pipe converting Gray<->binary per item, with a Gray
// adjacency check against the previous Gray->binary item.
module gray_codec_pipe #(
    parameter int WIDTH = 4
) (
    input logic              clk_i,
    input logic              rst_i,
    gray_codec_pipe_if.slave pipe_io
);
    logic             en1, en2;
    logic             s1Valid_q, s1Valid_d;
    logic             s1Mode_q, s1Mode_d;
    logic [WIDTH-1:0] s1Data_q, s1Data_d;
    logic             s2Valid_q, s2Valid_d;
    logic             s2Mode_q, s2Mode_d;
    logic [WIDTH-1:0] s2Data_q, s2Data_d;
    logic             s2Err_q, s2Err_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             havePrev_q, havePrev_d;
    logic [WIDTH-1:0] binOut, grayOut, hamDiff;
    logic             multiBit;

    always_comb begin
        binOut  = '0;
        grayOut = s1Data_q ^ (s1Data_q >> 1);
        for (int i = 0; i < WIDTH; i++) begin
            binOut[i] = ^(s1Data_q >> i);
        end
        // Clearing the lowest set bit leaves something only if two or more bits differ.
        hamDiff  = s1Data_q ^ prev_q;
        multiBit = |(hamDiff & (hamDiff - WIDTH'(1)));
    end

    always_comb begin
        en2 = !s2Valid_q || pipe_io.out_ready;
        en1 = !s1Valid_q || en2;

        s1Valid_d  = s1Valid_q;
        s1Mode_d   = s1Mode_q;
        s1Data_d   = s1Data_q;
        s2Valid_d  = s2Valid_q;
        s2Mode_d   = s2Mode_q;
        s2Data_d   = s2Data_q;
        s2Err_d    = s2Err_q;
        prev_d     = prev_q;
        havePrev_d = havePrev_q;

        if (en1) begin
            s1Valid_d = pipe_io.in_valid;
            s1Mode_d  = pipe_io.in_mode;
            s1Data_d  = pipe_io.in_data;
        end

        // Bubbles advance the valid bit only, so S2 payload keeps its last item.
        if (en2) begin
            s2Valid_d = s1Valid_q;
            if (s1Valid_q) begin
                s2Mode_d = s1Mode_q;
                s2Data_d = s1Mode_q ? grayOut : binOut;
                s2Err_d  = 1'b0;
                if (!s1Mode_q) begin
                    s2Err_d    = havePrev_q && multiBit;
                    prev_d     = s1Data_q;
                    havePrev_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1Valid_q  <= 1'b0;
            s1Mode_q   <= 1'b0;
            s1Data_q   <= '0;
            s2Valid_q  <= 1'b0;
            s2Mode_q   <= 1'b0;
            s2Data_q   <= '0;
            s2Err_q    <= 1'b0;
            prev_q     <= '0;
            havePrev_q <= 1'b0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Mode_q   <= s1Mode_d;
            s1Data_q   <= s1Data_d;
            s2Valid_q  <= s2Valid_d;
            s2Mode_q   <= s2Mode_d;
            s2Data_q   <= s2Data_d;
            s2Err_q    <= s2Err_d;
            prev_q     <= prev_d;
            havePrev_q <= havePrev_d;
        end
    end

    assign pipe_io.in_ready    = en1;
    assign pipe_io.out_valid   = s2Valid_q;
    assign pipe_io.out_mode    = s2Mode_q;
    assign pipe_io.out_data    = s2Data_q;
    assign pipe_io.out_adj_err = s2Err_q;
endmodule

// File: tb/tb_gray_codec_pipe.sv
// Scoreboard bench: WIDTH 8, 4 and 1 converters run in lockstep on shared
// stimulus; each accepted item queues the reference results for all three.
module tb_gray_codec_pipe;
    typedef struct packed {
        logic            mode;
        logic [2:0][7:0] d;
        logic [2:0]      e;
        int              cyc;
        logic            chkLat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inValid = 1'b0;
    logic       inMode = 1'b0;
    logic [7:0] inData = 8'h00;
    logic       outReady = 1'b1;
    logic       randomRun = 1'b0;
    logic       gapCheck = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int inCount = 0;
    int outCount = 0;
    int lastPop = -1;

    exp_t       expQ[$];
    logic [7:0] prevM[3];
    logic       haveM[3];
    int         widths[3] = '{8, 4, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gray_codec_pipe_if #(.WIDTH(8)) if8 ();
    gray_codec_pipe_if #(.WIDTH(4)) if4 ();
    gray_codec_pipe_if #(.WIDTH(1)) if1 ();

    gray_codec_pipe #(.WIDTH(8)) dut8 (.clk_i(clk), .rst_i(rst), .pipe_io(if8));
    gray_codec_pipe #(.WIDTH(4)) dut4 (.clk_i(clk), .rst_i(rst), .pipe_io(if4));
    gray_codec_pipe #(.WIDTH(1)) dut1 (.clk_i(clk), .rst_i(rst), .pipe_io(if1));

    assign if8.in_valid  = inValid;
    assign if4.in_valid  = inValid;
    assign if1.in_valid  = inValid;
    assign if8.in_mode   = inMode;
    assign if4.in_mode   = inMode;
    assign if1.in_mode   = inMode;
    assign if8.in_data   = inData;
    assign if4.in_data   = inData[3:0];
    assign if1.in_data   = inData[0:0];
    assign if8.out_ready = outReady;
    assign if4.out_ready = outReady;
    assign if1.out_ready = outReady;

    logic [2:0]      actV, actM, actE, actR;
    logic [2:0][7:0] actD;
    assign actV = {if1.out_valid, if4.out_valid, if8.out_valid};
    assign actM = {if1.out_mode, if4.out_mode, if8.out_mode};
    assign actE = {if1.out_adj_err, if4.out_adj_err, if8.out_adj_err};
    assign actR = {if1.in_ready, if4.in_ready, if8.in_ready};
    assign actD = {7'b0, if1.out_data, 4'b0, if4.out_data, if8.out_data};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Gray->binary by searching for the value whose Gray code matches.
    function automatic logic [7:0] refConvert(input logic mode, input logic [7:0] x, input int w);
        logic [7:0] mask = 8'hFF >> (8 - w);
        logic [7:0] vv;
        if (mode) return (x ^ (x >> 1)) & mask;
        for (int v = 0; v < (1 << w); v++) begin
            vv = 8'(v);
            if (((vv ^ (vv >> 1)) & mask) == x) return vv;
        end
        return 8'h00;
    endfunction

    task automatic modelAccept(input logic mode, input logic [7:0] data, input logic lat);
        exp_t       e;
        logic [7:0] x;
        e.mode   = mode;
        e.cyc    = cyc;
        e.chkLat = lat;
        for (int k = 0; k < 3; k++) begin
            x = data & (8'hFF >> (8 - widths[k]));
            e.d[k] = refConvert(mode, x, widths[k]);
            e.e[k] = 1'b0;
            if (!mode) begin
                e.e[k]   = haveM[k] && ($countones(x ^ prevM[k]) > 1);
                prevM[k] = x;
                haveM[k] = 1'b1;
            end
        end
        expQ.push_back(e);
        inCount++;
    endtask

    task automatic applyStimulus(input logic mode, input logic [7:0] data, input logic lat, output int waited);
        inValid = 1'b1;
        inMode  = mode;
        inData  = data;
        waited  = 0;
        forever begin
            @(negedge clk);
            if (if8.in_ready) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) checkOutput("accept timeout", 64'd0, 64'd1);
        else modelAccept(mode, data, lat);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        inValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        for (int k = 0; k < 3; k++) begin
            prevM[k] = 8'h00;
            haveM[k] = 1'b0;
        end
        @(negedge clk);
        checkOutput("reset out_valid", 64'(actV), 64'd0);
        checkOutput("reset out_data", 64'(actD), 64'd0);
        checkOutput("reset mode/err", 64'({actM, actE}), 64'd0);
        checkOutput("reset in_ready", 64'(actR), 64'd7);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain", 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every output transfer, and checks stalled outputs stay put.
    initial begin
        exp_t        e;
        logic        holdPrev = 1'b0;
        logic [32:0] heldVals = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holdPrev = 1'b0;
            end else begin
                if (holdPrev) checkOutput("stall hold", 64'({actV, actM, actE, actD}), 64'(heldVals));
                if (actV[0] && outReady) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected output", 64'(actD), 64'hDEAD);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("out_valid lockstep", 64'(actV), 64'd7);
                        checkOutput("out_data", 64'(actD), 64'(e.d));
                        checkOutput("out_adj_err", 64'(actE), 64'(e.e));
                        checkOutput("out_mode", 64'(actM), 64'({3{e.mode}}));
                        if (e.chkLat) checkOutput("latency", 64'(cyc - e.cyc), 64'd2);
                        if (gapCheck && lastPop >= 0) checkOutput("no gap", 64'(cyc - lastPop), 64'd1);
                        lastPop = cyc;
                        outCount++;
                    end
                end
                holdPrev = actV[0] && !outReady;
                heldVals = {actV, actM, actE, actD};
            end
        end
    end

    // Random backpressure while the regression runs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randomRun) outReady = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         w;
        int         in0, out0;
        logic       m;
        logic [7:0] d, lastG;

        doReset();

        // Gray inputs counting in binary, full throughput.
        for (int g = 0; g < 16; g++) begin
            applyStimulus(1'b0, 8'(g), 1'b1, w);
            checkOutput("stream in_ready", 64'(w), 64'd0);
        end
        waitDrain();

        applyStimulus(1'b1, 8'h05, 1'b1, w);
        applyStimulus(1'b1, 8'h08, 1'b1, w);
        applyStimulus(1'b1, 8'h0F, 1'b1, w);
        waitDrain();

        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1, w);
        applyStimulus(1'b0, 8'h01, 1'b1, w);
        applyStimulus(1'b0, 8'h03, 1'b1, w);
        applyStimulus(1'b0, 8'h00, 1'b1, w);
        applyStimulus(1'b0, 8'h00, 1'b1, w);
        applyStimulus(1'b1, 8'h0F, 1'b1, w);
        applyStimulus(1'b0, 8'h04, 1'b1, w);
        waitDrain();

        // Backpressure: two items buffer, the third waits for out_ready.
        outReady = 1'b0;
        applyStimulus(1'b0, 8'h03, 1'b0, w);
        applyStimulus(1'b1, 8'h05, 1'b0, w);
        inValid = 1'b1;
        inMode  = 1'b0;
        inData  = 8'h07;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("backpressure in_ready", 64'(actR), 64'd0);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        lastPop  = -1;
        gapCheck = 1'b1;
        applyStimulus(1'b0, 8'h07, 1'b0, w);
        checkOutput("in_ready on out_ready rise", 64'(w), 64'd0);
        waitDrain();
        gapCheck = 1'b0;

        // Reset with both stages full.
        outReady = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, w);
        applyStimulus(1'b0, 8'h00, 1'b0, w);
        @(negedge clk);
        checkOutput("full before reset", 64'({actV, actR}), 64'h38);
        doReset();
        outReady = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h0A, 1'b1, w);
        waitDrain();

        // Random regression.
        in0 = inCount;
        out0 = outCount;
        lastG = 8'h00;
        randomRun = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            m = ($urandom_range(0, 3) == 0);
            if (!m && $urandom_range(0, 1) == 1) d = lastG ^ (8'd1 << $urandom_range(0, 7));
            else d = 8'($urandom);
            if (!m) lastG = d;
            applyStimulus(m, d, 1'b0, w);
        end
        randomRun = 1'b0;
        @(posedge clk);
        #1;
        outReady = 1'b1;
        waitDrain();
        checkOutput("items out", 64'(outCount - out0), 64'd1000);
        checkOutput("items in vs out", 64'(outCount - out0), 64'(inCount - in0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
